// File: rtl/ser_pkg.sv
// Shared definitions for the serial receive path.
//   state_t        : receiver FSM states
//   FRAME_LEN_DEF  : default frame length in bits
//   FRAME_CNT_W    : width of the completed-frame counter (wraps)
//   ERR_CNT_W      : width of the aborted-frame counter (saturates)
package ser_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int FRAME_LEN_DEF = 16;
  localparam int FRAME_CNT_W   = 8;
  localparam int ERR_CNT_W     = 4;
endpackage

// File: rtl/ser_bit_counter.sv
// Bit position counter for the current partial frame.
//   clk, rst : clock, async active-high reset
//   clkEn    : counter only moves when set
//   inc      : advance by one
//   clr      : synchronous clear, wins over inc
//   count    : bits collected so far
//   tc       : count sits at FRAME_LEN-1 (next accepted bit closes the frame)
module ser_bit_counter #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             tc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clkEn) begin
      if (clr)      count <= '0;
      else if (inc) count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(FRAME_LEN - 1));
endmodule

// File: rtl/ser_deserializer.sv
// Serial-to-parallel receiver. Packs each uninterrupted run of FRAME_LEN
// qualified bits (MSB first) into a word and keeps frame/error counters.
//   clk, rst   : clock, async active-high reset
//   clkEn      : sampling enable shared with the transmitter
//   serIn      : serial data
//   serInValid : serial data qualifier; a drop mid-frame aborts the frame
//   dataOut    : last completed frame
//   dataValid  : one-clk strobe on a new dataOut
//   bitCount   : bits held in the current partial frame
//   frameCount : completed frames, wraps
//   shortFrame : one-clk strobe on an aborted frame
//   errCount   : aborted frames, saturates
module ser_deserializer
  import ser_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clkEn,
  input  logic                   serIn,
  input  logic                   serInValid,
  output logic [FRAME_LEN-1:0]   dataOut,
  output logic                   dataValid,
  output logic [CNT_W-1:0]       bitCount,
  output logic [FRAME_CNT_W-1:0] frameCount,
  output logic                   shortFrame,
  output logic [ERR_CNT_W-1:0]   errCount
);
  state_t               state;
  logic [FRAME_LEN-2:0] shift;
  logic [FRAME_LEN-1:0] shift_nxt;
  logic                 cnt_tc, cnt_inc, cnt_clr;

  // Only FRAME_LEN-1 bits need storing: the last bit goes straight to dataOut.
  assign shift_nxt = {shift, serIn};

  // In IDLE the counter is always 0, so tc can only fire in SHIFT.
  assign cnt_clr = (state == SHIFT) && (!serInValid || cnt_tc);
  assign cnt_inc = serInValid && !cnt_clr;

  ser_bit_counter #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clkEn (clkEn),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (bitCount),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      dataOut    <= '0;
      dataValid  <= 1'b0;
      shortFrame <= 1'b0;
      frameCount <= '0;
      errCount   <= '0;
    end else begin
      // Strobes last one clk regardless of clkEn.
      dataValid  <= 1'b0;
      shortFrame <= 1'b0;
      if (clkEn) begin
        case (state)
          IDLE: begin
            if (serInValid) begin
              shift <= shift_nxt[FRAME_LEN-2:0];
              state <= SHIFT;
            end
          end
          SHIFT: begin
            if (serInValid) begin
              shift <= shift_nxt[FRAME_LEN-2:0];
              if (cnt_tc) begin
                dataOut    <= shift_nxt;
                dataValid  <= 1'b1;
                frameCount <= frameCount + 1'b1;
                state      <= IDLE;
              end
            end else begin
              shortFrame <= 1'b1;
              if (errCount != '1) errCount <= errCount + 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
